// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge used by both the register write path and the read bypass.
// Pure combinational helper; there is no state and no flow control.
package regfile_pkg;
   localparam int DEF_M      = 32;
   localparam int DEF_NREGS  = 16;
   localparam int DEF_PC_IDX = 15;
   localparam int MAX_M      = 256;

   // Operands are MAX_M wide so a single function serves every M; callers zero-extend and truncate.
   function automatic logic [MAX_M-1:0] lane_merge(input logic [MAX_M-1:0]   old_w,
                                                   input logic [MAX_M-1:0]   new_w,
                                                   input logic [MAX_M/8-1:0] be);
      logic [MAX_M-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_M/8; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for the hazard unit: set on issue, cleared on writeback, set wins a same-cycle race.
// State updates on the clock edge; busy taps read registered state only, no backpressure.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = DEF_NREGS,
   parameter int AW     = $clog2(DEF_NREGS),
   parameter int PC_IDX = DEF_PC_IDX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [AW-1:0]    clr_addr,
   input  logic             set,
   input  logic [AW-1:0]    set_addr,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic             busy1,
   output logic             busy2,
   output logic [NREGS-1:0] busy_vec
);
   logic [NREGS-1:0] busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            // A fresh producer issuing in the same cycle as the old writeback keeps the bit set.
            if (set && int'(set_addr) == i && i != PC_IDX) busy[i] <= 1'b1;
            else if (clr && int'(clr_addr) == i)           busy[i] <= 1'b0;
         end
      end
   end

   assign busy_vec = busy;
   assign busy1    = (int'(ra1) < NREGS) ? busy[ra1] : 1'b0;
   assign busy2    = (int'(ra2) < NREGS) ? busy[ra2] : 1'b0;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational reads, one byte-enabled write, PC alias, busy scoreboard.
// Reads are zero-latency (optional write bypass), writes land on the clock edge; no backpressure.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int  M      = DEF_M,
   parameter int  NREGS  = DEF_NREGS,
   parameter bit  BYPASS = 1'b1,
   parameter int  PC_IDX = DEF_PC_IDX,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [M-1:0]     rd1,
   output logic [M-1:0]     rd2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [M-1:0]     wd,
   input  logic [M/8-1:0]   wbe,
   input  logic [M-1:0]     pc_plus8,
   input  logic             set_busy,
   input  logic [AW-1:0]    set_addr,
   output logic             busy1,
   output logic             busy2,
   output logic [NREGS-1:0] busy_vec
);
   if (M % 8 != 0) begin : g_bad_width
      $error("register_file_mp: M must be a multiple of 8");
   end
   if (M > MAX_M) begin : g_too_wide
      $error("register_file_mp: M exceeds MAX_M");
   end

   logic [M-1:0]     regs [NREGS];
   logic             wa_ok;
   logic             wr_en;
   logic [M-1:0]     wr_old;
   logic [MAX_M-1:0] merged_full;
   logic [M-1:0]     wr_merged;
   logic             unused_merge;

   assign wa_ok = int'(wa) < NREGS;
   assign wr_en = we && wa_ok && int'(wa) != PC_IDX;

   always_comb begin
      wr_old = '0;
      if (wa_ok) wr_old = regs[wa];
   end

   // The bypass hit has ra == wa, so the write-path merge is exactly the bypass value.
   assign merged_full  = lane_merge(MAX_M'(wr_old), MAX_M'(wd), (MAX_M/8)'(wbe));
   assign wr_merged    = merged_full[M-1:0];
   assign unused_merge = ^merged_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wa] <= wr_merged;
      end
   end

   logic [AW-1:0] ra_p [2];
   logic [M-1:0]  rd_p [2];
   assign ra_p[0] = ra1;
   assign ra_p[1] = ra2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_p[p] = '0;
         if (int'(ra_p[p]) == PC_IDX) begin
            rd_p[p] = pc_plus8;
         end else if (int'(ra_p[p]) < NREGS) begin
            if (BYPASS && we && ra_p[p] == wa) rd_p[p] = wr_merged;
            else                               rd_p[p] = regs[ra_p[p]];
         end
      end
   end

   assign rd1 = rd_p[0];
   assign rd2 = rd_p[1];

   regfile_scoreboard #(
      .NREGS  (NREGS),
      .AW     (AW),
      .PC_IDX (PC_IDX)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .clr      (wr_en),
      .clr_addr (wa),
      .set      (set_busy),
      .set_addr (set_addr),
      .ra1      (ra1),
      .ra2      (ra2),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy_vec (busy_vec)
   );
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed scenarios then random traffic against a behavioural model.
// Two instances (bypass on and off) share all inputs.
module tb_register_file_mp;
   localparam int M     = 32;
   localparam int NREGS = 16;
   localparam int AW    = 4;
   localparam int PC    = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, we, set_busy;
   logic [AW-1:0]    ra1, ra2, wa, set_addr;
   logic [M-1:0]     wd, pc_plus8;
   logic [M/8-1:0]   wbe;
   logic [M-1:0]     rd1_b, rd2_b, rd1_n, rd2_n;
   logic             busy1_b, busy2_b, busy1_n, busy2_n;
   logic [NREGS-1:0] bv_b, bv_n;

   register_file_mp #(.M(M), .NREGS(NREGS), .BYPASS(1'b1), .PC_IDX(PC)) dut_b (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .we(we), .wa(wa), .wd(wd), .wbe(wbe), .pc_plus8(pc_plus8),
      .set_busy(set_busy), .set_addr(set_addr),
      .busy1(busy1_b), .busy2(busy2_b), .busy_vec(bv_b));

   register_file_mp #(.M(M), .NREGS(NREGS), .BYPASS(1'b0), .PC_IDX(PC)) dut_n (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .we(we), .wa(wa), .wd(wd), .wbe(wbe), .pc_plus8(pc_plus8),
      .set_busy(set_busy), .set_addr(set_addr),
      .busy1(busy1_n), .busy2(busy2_n), .busy_vec(bv_n));

   logic [M-1:0] m_regs [NREGS];
   bit           m_busy [NREGS];
   int           vectors = 0;
   int           miscompares = 0;

   function automatic logic [M-1:0] merged(input logic [M-1:0] old_v);
      logic [M-1:0] mask;
      mask = {{8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};
      return (old_v & ~mask) | (wd & mask);
   endfunction

   function automatic logic [M-1:0] m_read(input logic [AW-1:0] ra, input bit byp);
      if (int'(ra) == PC) return pc_plus8;
      if (byp && we && ra == wa) return merged(m_regs[ra]);
      return m_regs[ra];
   endfunction

   task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NREGS-1:0] bv;
      #1;
      for (int i = 0; i < NREGS; i++) bv[i] = m_busy[i];
      check("rd1_byp",   rd1_b, m_read(ra1, 1'b1));
      check("rd2_byp",   rd2_b, m_read(ra2, 1'b1));
      check("rd1_nobyp", rd1_n, m_read(ra1, 1'b0));
      check("rd2_nobyp", rd2_n, m_read(ra2, 1'b0));
      check("busy1",     32'(busy1_b), 32'(m_busy[ra1]));
      check("busy2",     32'(busy2_n), 32'(m_busy[ra2]));
      check("busy_vec_b", 32'(bv_b), 32'(bv));
      check("busy_vec_n", 32'(bv_n), 32'(bv));
   endtask

   task automatic model_update();
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (we && int'(wa) != PC) begin
            m_regs[wa] = merged(m_regs[wa]);
            m_busy[wa] = 1'b0;
         end
         if (set_busy && int'(set_addr) != PC) m_busy[set_addr] = 1'b1;
      end
   endtask

   task automatic cycle();
      check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; set_busy = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; set_addr = '0;
      wd = '0; wbe = '0; pc_plus8 = '0;
      @(posedge clk);
      model_update();
      @(negedge clk);

      // Reset then read
      reset = 1'b0; ra1 = 4'd3; ra2 = 4'd15; pc_plus8 = 32'h0000_0108;
      #1;
      check("reset_rd1", rd1_b, 32'h0);
      check("reset_pc", rd2_b, 32'h0000_0108);
      check("reset_busy", 32'(bv_b), 32'h0);
      cycle();

      // Byte-lane write
      we = 1'b1; wa = 4'd5; wd = 32'hAABB_CCDD; wbe = 4'b1111; ra1 = 4'd5;
      cycle();
      wd = 32'h1122_3344; wbe = 4'b0101;
      cycle();
      we = 1'b0;
      #1 check("lane_merge", rd1_n, 32'hAA22_CC44);
      cycle();

      // Bypass on/off
      we = 1'b1; wa = 4'd2; wd = 32'h10; wbe = 4'hF;
      cycle();
      wd = 32'h55; ra1 = 4'd2;
      #1;
      check("bypass_new", rd1_b, 32'h55);
      check("nobypass_old", rd1_n, 32'h10);
      cycle();
      we = 1'b0;
      #1 check("nobypass_next", rd1_n, 32'h55);
      cycle();

      // PC protection, busy on PC ignored
      pc_plus8 = 32'h0000_0200; we = 1'b1; wa = 4'd15; wd = 32'hDEAD_BEEF; ra1 = 4'd15;
      set_busy = 1'b1; set_addr = 4'd15;
      cycle();
      we = 1'b0; set_busy = 1'b0;
      #1;
      check("pc_alias", rd1_b, 32'h0000_0200);
      check("pc_not_busy", 32'(bv_b), 32'h0);
      cycle();

      // Scoreboard race
      set_busy = 1'b1; set_addr = 4'd4; ra1 = 4'd4;
      cycle();
      set_busy = 1'b0;
      #1 check("busy_set", 32'(busy1_b), 32'h1);
      cycle();
      we = 1'b1; wa = 4'd4; wd = 32'h1234_5678; set_busy = 1'b1; set_addr = 4'd4;
      cycle();
      we = 1'b0; set_busy = 1'b0;
      #1 check("busy_race", 32'(bv_b[4]), 32'h1);
      cycle();
      we = 1'b1;
      cycle();
      we = 1'b0;
      #1 check("busy_clear", 32'(busy1_b), 32'h0);
      cycle();

      // Reset mid-operation
      we = 1'b1; wa = 4'd7; wd = 32'h77; wbe = 4'hF;
      cycle();
      we = 1'b0; set_busy = 1'b1;
      for (int a = 4; a < 8; a++) begin
         set_addr = AW'(a);
         cycle();
      end
      set_busy = 1'b0;
      #1 check("busy_pre_reset", 32'(bv_b), 32'h0000_00F0);
      reset = 1'b1; we = 1'b1; wa = 4'd7; wd = 32'hFFFF_FFFF; set_busy = 1'b1; set_addr = 4'd6;
      cycle();
      reset = 1'b0; we = 1'b0; set_busy = 1'b0; ra1 = 4'd7;
      #1;
      check("reset_reg7", rd1_n, 32'h0);
      check("reset_busy_vec", 32'(bv_n), 32'h0);
      cycle();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 49) == 0);
         we       = 1'($urandom_range(0, 1));
         wa       = AW'($urandom_range(0, NREGS - 1));
         wd       = $urandom;
         wbe      = 4'($urandom_range(0, 15));
         pc_plus8 = $urandom;
         set_busy = 1'($urandom_range(0, 1));
         set_addr = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         ra1      = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         ra2      = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
